div_clk_monitor: RTL

//  Downstream checker for the divide-by-N clock stages. Samples the divided output (DIV_IN)
//  as data in the source clock domain and measures each high/low run length in CLK_IN cycles.

---
 rtl/div_clk_monitor.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/div_clk_monitor.sv
// Run-length checker for a divided clock sampled in its source domain.
// Tracks lock on consecutive in-tolerance high/low runs and flags loss of lock.
module div_clk_monitor #(
  parameter int EXP_HALF = 5,
  parameter int TOL      = 0,
  parameter int LOCK_CNT = 4,
  parameter int CNT_W    = 8
) (
  input  logic             CLK_IN,
  input  logic             RST_N,
  input  logic             EN,
  input  logic             DIV_IN,
  output logic [CNT_W-1:0] HALF_LEN,
  output logic             HALF_VALID,
  output logic             LOCKED,
  output logic             ERR,
  output logic [7:0]       ERR_CNT,
  output logic [15:0]      PERIOD_CNT
);

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int unsigned LO =
    (EXP_HALF > TOL) ? EXP_HALF - TOL : 0;
  localparam int unsigned HI = EXP_HALF + TOL;
  localparam int unsigned TMO = HI + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SYNC,
    S_MEAS,
    S_LOCK
  } state_t;

  state_t          state_q, state_d;
  logic            d1, d2;
  logic            edg, rise;
  logic [CNT_W-1:0] run_cnt;
  logic [31:0]     run_ext;
  logic [GW-1:0]   good_q, good_d;
  logic            good, tmo;
  logic            hv_d, err_d;
  logic            pcnt_inc, ecnt_inc;

  assign edg     = d1 ^ d2;
  assign rise    = d1 & ~d2;
  assign run_ext = 32'(run_cnt);
  assign good    = (run_ext >= LO) && (run_ext <= HI);
  assign tmo     = !edg && (run_ext == TMO);
  assign LOCKED  = (state_q == S_LOCK);

  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      d1 <= 1'b0;
      d2 <= 1'b0;
    end else begin
      d1 <= DIV_IN;
      d2 <= d1;
    end
  end

  // Counter freezes in IDLE; saturation keeps timeout to one shot per run
  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      run_cnt <= '0;
    end else if (state_q != S_IDLE) begin
      if (edg)
        run_cnt <= CNT_W'(1);
      else if (run_cnt != '1)
        run_cnt <= run_cnt + 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    good_d   = good_q;
    hv_d     = 1'b0;
    err_d    = 1'b0;
    pcnt_inc = 1'b0;
    ecnt_inc = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (EN) state_d = S_SYNC;
      end
      S_SYNC: begin
        if (edg) begin
          state_d = S_MEAS;
          good_d  = '0;
        end
      end
      S_MEAS: begin
        if (edg) begin
          hv_d = 1'b1;
          if (good) begin
            good_d = good_q + 1'b1;
            if (good_q == GW'(LOCK_CNT - 1))
              state_d = S_LOCK;
          end else begin
            good_d = '0;
          end
        end else if (tmo) begin
          good_d = '0;
        end
      end
      S_LOCK: begin
        if (edg) begin
          hv_d = 1'b1;
          if (good) begin
            pcnt_inc = rise;
          end else begin
            err_d    = 1'b1;
            ecnt_inc = 1'b1;
            state_d  = S_MEAS;
            good_d   = '0;
          end
        end else if (tmo) begin
          err_d    = 1'b1;
          ecnt_inc = 1'b1;
          state_d  = S_SYNC;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Disable overrides everything but the run report
    if (!EN) begin
      state_d  = S_IDLE;
      good_d   = '0;
      err_d    = 1'b0;
      pcnt_inc = 1'b0;
      ecnt_inc = 1'b0;
    end
  end

  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= S_IDLE;
      good_q     <= '0;
      HALF_VALID <= 1'b0;
      ERR        <= 1'b0;
      HALF_LEN   <= '0;
      ERR_CNT    <= '0;
      PERIOD_CNT <= '0;
    end else begin
      state_q    <= state_d;
      good_q     <= good_d;
      HALF_VALID <= hv_d;
      ERR        <= err_d;
      if (hv_d)
        HALF_LEN <= run_cnt;
      if (ecnt_inc && (ERR_CNT != 8'hFF))
        ERR_CNT <= ERR_CNT + 1'b1;
      if (pcnt_inc)
        PERIOD_CNT <= PERIOD_CNT + 1'b1;
    end
  end

endmodule
